// File: rtl/hex_display_scheduler.sv
// Time-multiplexes one shared seven-segment decoder across DIGITS displays.
// Each accepted value is scanned MSB-first, one digit per clock, into per-display registers.
module hex_display_scheduler #(
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_en,
    input  logic                  load,
    output logic                  ready,
    output logic                  done,
    output logic [3:0]            dec_nibble,
    input  logic [6:0]            dec_seg,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t              state;
    logic [4*DIGITS-1:0] cap_value;
    logic [DIGITS-1:0]   cap_blank;
    logic                cap_lz;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       next_idx;
    logic                seen_nz;
    logic                last;
    logic                suppress;
    logic [6:0]          seg_out;

    // dec_nibble always holds the captured digit at idx, so it doubles as the current digit.
    always_comb begin
        last     = (idx == '0);
        next_idx = idx - IW'(1);
        suppress = cap_lz && !seen_nz && (dec_nibble == 4'h0) && !last;
        seg_out  = (cap_blank[idx] || suppress) ? 7'h7F : dec_seg;
    end

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values; blocking writes would let idx/dec_nibble race within the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ready      <= 1'b1;
            done       <= 1'b0;
            dec_nibble <= 4'h0;
            hex        <= {DIGITS{7'h7F}};
            cap_value  <= '0;
            cap_blank  <= '0;
            cap_lz     <= 1'b0;
            idx        <= '0;
            seen_nz    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        cap_value  <= value;
                        cap_blank  <= blank;
                        cap_lz     <= lz_en;
                        idx        <= IW'(DIGITS - 1);
                        seen_nz    <= 1'b0;
                        dec_nibble <= value[4*(DIGITS-1) +: 4];
                        ready      <= 1'b0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    hex[7*idx +: 7] <= seg_out;
                    // Force-blanked nonzero digits still end the leading-zero run.
                    seen_nz <= seen_nz | (dec_nibble != 4'h0);
                    if (last) begin
                        state      <= IDLE;
                        ready      <= 1'b1;
                        done       <= 1'b1;
                        dec_nibble <= 4'h0;
                    end else begin
                        idx        <= next_idx;
                        dec_nibble <= cap_value[4*next_idx +: 4];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler with a behavioural DE10 seven-segment decoder.
module tb_hex_display_scheduler;

    localparam int D = 6;

    logic           clk;
    logic           reset;
    logic [4*D-1:0] value;
    logic [D-1:0]   blank;
    logic           lz_en;
    logic           load;
    logic           ready;
    logic           done;
    logic [3:0]     dec_nibble;
    logic [6:0]     dec_seg;
    logic [7*D-1:0] hex;

    int vectors;
    int miscompares;

    logic [7*D-1:0] cur_hex;
    localparam logic [7*D-1:0] ALL_DARK = {D{7'h7F}};

    hex_display_scheduler #(.DIGITS(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .blank      (blank),
        .lz_en      (lz_en),
        .load       (load),
        .ready      (ready),
        .done       (done),
        .dec_nibble (dec_nibble),
        .dec_seg    (dec_seg),
        .hex        (hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low gfedcba patterns for the DE10 Lite displays.
    always_comb begin
        case (dec_nibble)
            4'h0: dec_seg = 7'b1000000;
            4'h1: dec_seg = 7'b1111001;
            4'h2: dec_seg = 7'b0100100;
            4'h3: dec_seg = 7'b0110000;
            4'h4: dec_seg = 7'b0011001;
            4'h5: dec_seg = 7'b0010010;
            4'h6: dec_seg = 7'b0000010;
            4'h7: dec_seg = 7'b1111000;
            4'h8: dec_seg = 7'b0000000;
            4'h9: dec_seg = 7'b0010000;
            4'hA: dec_seg = 7'b0001000;
            4'hB: dec_seg = 7'b0000011;
            4'hC: dec_seg = 7'b1000110;
            4'hD: dec_seg = 7'b0100001;
            4'hE: dec_seg = 7'b0000110;
            default: dec_seg = 7'b0001110;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        value = '0;
        blank = '0;
        lz_en = 1'b0;
        load  = 1'b0;
        #1;
        vectors++;
        if (hex !== ALL_DARK) begin
            miscompares++;
            $display("FAIL reset_hex: got %h expected %h", hex, ALL_DARK);
        end
        vectors++;
        if (ready !== 1'b1 || done !== 1'b0 || dec_nibble !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got ready=%b done=%b nib=%h expected ready=1 done=0 nib=0",
                     ready, done, dec_nibble);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (hex !== ALL_DARK || ready !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got hex=%h ready=%b done=%b expected hex=%h ready=1 done=0",
                     hex, ready, done, ALL_DARK);
        end
        cur_hex = ALL_DARK;
    endtask

    // Called #1 after the accepting edge; ends #1 after the final write edge (the done cycle).
    task automatic expect_scan(input string name, input logic [7*D-1:0] prev,
                               input logic [7*D-1:0] fin);
        logic [7*D-1:0] exp;
        vectors++;
        if (ready !== 1'b0 || done !== 1'b0 || hex !== prev) begin
            miscompares++;
            $display("FAIL %s_accept: got ready=%b done=%b hex=%h expected ready=0 done=0 hex=%h",
                     name, ready, done, hex, prev);
        end
        for (int k = 0; k < D; k++) begin
            tick();
            for (int i = 0; i < D; i++)
                exp[7*i +: 7] = (i >= D-1-k) ? fin[7*i +: 7] : prev[7*i +: 7];
            vectors++;
            if (hex !== exp) begin
                miscompares++;
                $display("FAIL %s_edge%0d_hex: got %h expected %h", name, k+1, hex, exp);
            end
            vectors++;
            if (k < D-1) begin
                if (done !== 1'b0 || ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s_edge%0d_ctrl: got done=%b ready=%b expected done=0 ready=0",
                             name, k+1, done, ready);
                end
            end else begin
                if (done !== 1'b1 || ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s_done: got done=%b ready=%b expected done=1 ready=1",
                             name, done, ready);
                end
            end
        end
    endtask

    task automatic scan_check(input string name, input logic [4*D-1:0] v, input logic [D-1:0] b,
                              input logic lz, input logic [7*D-1:0] fin);
        value = v;
        blank = b;
        lz_en = lz;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        value = ~v;
        blank = ~b;
        lz_en = ~lz;
        expect_scan(name, cur_hex, fin);
        tick();
        vectors++;
        if (done !== 1'b0 || ready !== 1'b1 || hex !== fin || dec_nibble !== 4'h0) begin
            miscompares++;
            $display("FAIL %s_after: got done=%b ready=%b nib=%h hex=%h expected done=0 ready=1 nib=0 hex=%h",
                     name, done, ready, dec_nibble, hex, fin);
        end
        cur_hex = fin;
    endtask

    task automatic test_basic();
        scan_check("basic", 24'h12A3F0, 6'b000000, 1'b0,
                   {7'b1111001, 7'b0100100, 7'b0001000, 7'b0110000, 7'b0001110, 7'b1000000});
    endtask

    task automatic test_lz();
        scan_check("lz_a5", 24'h0000A5, 6'b000000, 1'b1,
                   {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b0001000, 7'b0010010});
        scan_check("lz_zero", 24'h000000, 6'b000000, 1'b1,
                   {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b1000000});
        scan_check("lz_blank", 24'h000700, 6'b000100, 1'b1,
                   {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b1000000, 7'b1000000});
    endtask

    task automatic test_blank();
        scan_check("blank_mask", 24'h123456, 6'b101010, 1'b0,
                   {7'h7F, 7'b0100100, 7'h7F, 7'b0011001, 7'h7F, 7'b0000010});
    endtask

    task automatic test_back_to_back();
        logic [7*D-1:0] fin_a;
        logic [7*D-1:0] fin_b;
        fin_a = {7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000};
        fin_b = {D{7'b1111001}};
        value = 24'hFEDCBA;
        blank = '0;
        lz_en = 1'b0;
        load  = 1'b1;
        tick();
        // load stays high with a different value: must be ignored mid-scan
        value = 24'h111111;
        expect_scan("b2b_first", cur_hex, fin_a);
        tick();
        load = 1'b0;
        value = 24'h999999;
        expect_scan("b2b_second", fin_a, fin_b);
        tick();
        vectors++;
        if (done !== 1'b0 || ready !== 1'b1 || hex !== fin_b) begin
            miscompares++;
            $display("FAIL b2b_after: got done=%b ready=%b hex=%h expected done=0 ready=1 hex=%h",
                     done, ready, hex, fin_b);
        end
        cur_hex = fin_b;
    endtask

    task automatic test_reset_mid_scan();
        int done_seen;
        value = 24'h888888;
        blank = '0;
        lz_en = 1'b0;
        load  = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (hex !== ALL_DARK || ready !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got hex=%h ready=%b done=%b expected hex=%h ready=1 done=0",
                     hex, ready, done, ALL_DARK);
        end
        tick();
        tick();
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        vectors++;
        if (done_seen != 0) begin
            miscompares++;
            $display("FAIL mid_reset_no_done: got %0d done pulses expected 0", done_seen);
        end
        vectors++;
        if (hex !== ALL_DARK || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_idle: got hex=%h ready=%b expected hex=%h ready=1",
                     hex, ready, ALL_DARK);
        end
        cur_hex = ALL_DARK;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_lz();
        test_blank();
        test_back_to_back();
        test_reset_mid_scan();
        scan_check("post_reset", 24'h12A3F0, 6'b000000, 1'b0,
                   {7'b1111001, 7'b0100100, 7'b0001000, 7'b0110000, 7'b0001110, 7'b1000000});
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
